key_conditioner: RTL and testbench

// - Front end for the pushbutton keys that drive the time-setting FSM.
// - Synchronises the raw active-low KEY inputs to clk50 and debounces them.
// - Emits clean one-cycle press and release events per key.
// - Optionally emits auto-repeat pulses, so a held key steps seconds, minutes or hours rapidly.
// - Sits between the board KEY pins and the FSM key inputs; the FSM consumes only the pulses.

---
 rtl/key_conditioner.sv | 178 +++++++++++++++++
 tb/tb_key_conditioner.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/key_conditioner.sv
// Pushbutton front end: 2-flop sync, debounce, press/release pulses per key.
// Define KEY_AUTOREPEAT_EN to build the held-key auto-repeat timer.

module key_chan #(
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int REPEAT_DELAY    = 25_000_000,
    parameter int REPEAT_RATE     = 5_000_000
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic key_ni,
    output logic level_o,
    output logic press_o,
    output logic release_o,
    output logic repeat_o
);
    localparam int             CW       = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0]  CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [2:0] {IDLE, ARM, HELD, RPT, DISARM} state_e;

    state_e        state_q, state_d;
    logic          sync1_q, s_q;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          level_q, level_d, press_q, press_d;
    logic          release_q, release_d, repeat_q, repeat_d;
    logic          deb, diff, cnt_hit, tmr_hit, back_rpt;

    // deb is the debounced "pressed" state; s_q is active-low
    assign deb     = (state_q == HELD) || (state_q == RPT) || (state_q == DISARM);
    assign diff    = (~s_q) != deb;
    assign cnt_hit = diff && (cnt_q == CNT_LAST);

`ifdef KEY_AUTOREPEAT_EN
    localparam int RMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int TW   = $clog2(RMAX + 1);
    localparam logic [TW-1:0] RD_T = TW'(REPEAT_DELAY);
    localparam logic [TW-1:0] RR_T = TW'(REPEAT_RATE);

    logic [TW-1:0] tmr_q, tmr_d, tmr_inc, tmr_tgt;
    logic          from_rpt_q, from_rpt_d;

    assign tmr_inc  = (tmr_q == '1) ? tmr_q : tmr_q + TW'(1);
    assign tmr_tgt  = ((state_q == RPT) || (state_q == DISARM && from_rpt_q)) ? RR_T : RD_T;
    assign tmr_hit  = tmr_inc >= tmr_tgt;
    assign back_rpt = from_rpt_q;

    // Timer keeps running through DISARM but parks at its target there,
    // so a bounce back into HELD/RPT fires the overdue repeat at once.
    always_comb begin
        tmr_d      = tmr_inc;
        from_rpt_d = from_rpt_q;
        if (state_q == IDLE || state_q == ARM || repeat_d)
            tmr_d = '0;
        else if (state_q == DISARM && tmr_hit)
            tmr_d = tmr_tgt;
        if (state_q == HELD)
            from_rpt_d = 1'b0;
        else if (state_q == RPT)
            from_rpt_d = 1'b1;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            tmr_q      <= '0;
            from_rpt_q <= 1'b0;
        end else begin
            tmr_q      <= tmr_d;
            from_rpt_q <= from_rpt_d;
        end
    end
`else
    localparam int rpt_unused = REPEAT_DELAY + REPEAT_RATE;
    assign tmr_hit  = 1'b0;
    assign back_rpt = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        cnt_d     = '0;
        press_d   = 1'b0;
        release_d = 1'b0;
        repeat_d  = 1'b0;
        if (diff && !cnt_hit)
            cnt_d = cnt_q + CW'(1);
        case (state_q)
            IDLE, ARM: begin
                if (!diff)
                    state_d = IDLE;
                else if (cnt_hit) begin
                    state_d = HELD;
                    press_d = 1'b1;
                end else
                    state_d = ARM;
            end
            HELD, RPT: begin
                if (diff) begin
                    if (cnt_hit) begin
                        state_d   = IDLE;
                        release_d = 1'b1;
                    end else
                        state_d = DISARM;
                end else if (tmr_hit) begin
                    state_d  = RPT;
                    repeat_d = 1'b1;
                end
            end
            DISARM: begin
                if (!diff)
                    state_d = back_rpt ? RPT : HELD;
                else if (cnt_hit) begin
                    state_d   = IDLE;
                    release_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        level_d = (state_d == HELD) || (state_d == RPT) || (state_d == DISARM);
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            sync1_q   <= 1'b1;
            s_q       <= 1'b1;
            state_q   <= IDLE;
            cnt_q     <= '0;
            level_q   <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            repeat_q  <= 1'b0;
        end else begin
            sync1_q   <= key_ni;
            s_q       <= sync1_q;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            level_q   <= level_d;
            press_q   <= press_d;
            release_q <= release_d;
            repeat_q  <= repeat_d;
        end
    end

    assign level_o   = level_q;
    assign press_o   = press_q;
    assign release_o = release_q;
    assign repeat_o  = repeat_q;
endmodule

module key_conditioner #(
    parameter int NKEYS           = 4,
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int REPEAT_DELAY    = 25_000_000,
    parameter int REPEAT_RATE     = 5_000_000
) (
    input  logic             clk50,
    input  logic             reset,
    input  logic [NKEYS-1:0] key_n,
    output logic [NKEYS-1:0] key_level,
    output logic [NKEYS-1:0] key_press,
    output logic [NKEYS-1:0] key_release,
    output logic [NKEYS-1:0] key_repeat
);
    for (genvar g = 0; g < NKEYS; g++) begin : g_key
        key_chan #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .REPEAT_DELAY    (REPEAT_DELAY),
            .REPEAT_RATE     (REPEAT_RATE)
        ) u_chan (
            .clk_i     (clk50),
            .rst_ni    (reset),
            .key_ni    (key_n[g]),
            .level_o   (key_level[g]),
            .press_o   (key_press[g]),
            .release_o (key_release[g]),
            .repeat_o  (key_repeat[g])
        );
    end
endmodule

// File: tb/tb_key_conditioner.sv
// Scoreboard bench for key_conditioner: expected pulse events are queued when
// keys are driven and matched against the pulses the DUT emits.

module tb_key_conditioner;
    localparam int D  = 4;
    localparam int RD = 10;
    localparam int RR = 3;
    localparam int NC = 2048;

    typedef struct {
        int cyc;
        int key;
        int kind;   // 0 press, 1 release, 2 repeat
    } evt_t;

    logic       clk50 = 1'b0;
    logic       reset;
    logic [3:0] key_n;
    logic [3:0] key_level, key_press, key_release, key_repeat;

    int   cyc = 0;
    logic rst_at_edge = 1'b0;
    int   n_chk = 0;
    int   n_pass = 0;
    evt_t q[$];
    logic [3:0] lvl_exp [NC];

    key_conditioner #(
        .NKEYS           (4),
        .DEBOUNCE_CYCLES (D),
        .REPEAT_DELAY    (RD),
        .REPEAT_RATE     (RR)
    ) dut (
        .clk50       (clk50),
        .reset       (reset),
        .key_n       (key_n),
        .key_level   (key_level),
        .key_press   (key_press),
        .key_release (key_release),
        .key_repeat  (key_repeat)
    );

    always #5 clk50 = ~clk50;

    always @(posedge clk50) begin
        cyc++;
        rst_at_edge = reset;
    end

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s @cyc %0d: got %0d expected %0d", tag, cyc, got, exp);
    endtask

    function automatic void push_evt(input int c, input int k, input int kd);
        evt_t e;
        int   i = 0;
        e = '{c, k, kd};
        while (i < q.size() && (q[i].cyc < c || (q[i].cyc == c && q[i].key < k))) i++;
        q.insert(i, e);
    endfunction

    function automatic void set_lvl(input int k, input int from, input int to);
        for (int c = from; c < to && c < NC; c++) lvl_exp[c][k] = 1'b1;
    endfunction

    // Key k first sampled low at edge t0+1 and held for L sampled cycles.
    function automatic void exp_hold(input int k, input int t0, input int L);
        int p, rel, e;
        if (L < D) return;
        p   = t0 + 2 + D;
        rel = t0 + L + 2 + D;
        push_evt(p, k, 0);
`ifdef KEY_AUTOREPEAT_EN
        e = p + RD;
        while (e <= t0 + L + 2) begin
            push_evt(e, k, 2);
            e += RR;
        end
`else
        e = 0;
`endif
        push_evt(rel, k, 1);
        set_lvl(k, p, rel);
    endfunction

    task automatic obs(input int k, input int kind);
        evt_t e;
        if (q.size() == 0) begin
            chk("evt_unexpected", cyc * 16 + k * 4 + kind, -1);
        end else begin
            e = q.pop_front();
            chk("evt_cyc", cyc, e.cyc);
            chk("evt_key", k, e.key);
            chk("evt_kind", kind, e.kind);
        end
    endtask

    always @(negedge clk50) begin
        if (!rst_at_edge) begin
            chk("rst_outs", int'({key_level, key_press, key_release, key_repeat}), 0);
        end else begin
            for (int k = 0; k < 4; k++) begin
                if (key_press[k])   obs(k, 0);
                if (key_release[k]) obs(k, 1);
                if (key_repeat[k])  obs(k, 2);
            end
            if (cyc < NC) chk("level", int'(key_level), int'(lvl_exp[cyc]));
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk50);
        #1;
    endtask

    task automatic settle(input string tag);
        step(D + 8);
        chk({tag, "_pending"}, q.size(), 0);
        chk({tag, "_idle"}, int'(key_level), 0);
    endtask

    task automatic run_hold(input logic [3:0] mask, input int L, input string tag);
        int t0 = cyc;
        for (int k = 0; k < 4; k++) if (mask[k]) exp_hold(k, t0, L);
        key_n = ~mask;
        step(L);
        key_n = 4'hF;
        settle(tag);
    endtask

    initial begin
        int t0;
        for (int c = 0; c < NC; c++) lvl_exp[c] = 4'h0;
        reset = 1'b0;
        key_n = 4'h0;
        step(3);
        reset = 1'b1;
        run_hold(4'hF, 6, "rst_all");     // keys already low across reset
        run_hold(4'h1, 3, "glitch3");     // one short of the debounce count
        run_hold(4'h4, 1, "glitch1");
        run_hold(4'h2, 40, "hold40");
        run_hold(4'h4, 8, "hold8");
        run_hold(4'h9, 4, "dual_min");    // exactly the debounce count

        // release bounce shorter than the debounce window
        t0 = cyc;
        push_evt(t0 + 6, 3, 0);
        push_evt(t0 + 16, 3, 1);
        set_lvl(3, t0 + 6, t0 + 16);
        key_n = 4'h7;  step(6);
        key_n = 4'hF;  step(2);
        key_n = 4'h7;  step(2);
        key_n = 4'hF;
        settle("rel_bounce");

        // reset while a key is held; still held afterwards
        t0 = cyc;
        push_evt(t0 + 6, 2, 0);
        push_evt(t0 + 16, 2, 0);
        push_evt(t0 + 26, 2, 1);
        set_lvl(2, t0 + 6, t0 + 9);
        set_lvl(2, t0 + 16, t0 + 26);
        key_n = 4'hB;  step(8);
        reset = 1'b0;  step(2);
        reset = 1'b1;  step(10);
        key_n = 4'hF;
        settle("mid_reset");

        step(4);
        chk("final_pending", q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
